cfu_stim_checker: RTL and testbench

- Parametrised successor to the per-CFU bench scaffolding: one reusable LFSR-driven request generator plus in-order response checker for any CFU.
- Issues N_REQS random requests over the req/resp handshake, keeps up to DEPTH requests outstanding, and compares each response against an external golden model.
- Reports pass, fail and timeout through counters and a done flag.
- One instance per CFU under test, side by side in the bench top.

---
 rtl/cfu_tb_pkg.sv | 21 ++
 rtl/cfu_tb_fifo.sv | 56 +++++
 rtl/cfu_stim_checker.sv | 205 ++++++++++++++++++++
 tb/tb_cfu_stim_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_tb_pkg.sv
// Shared types and constants for the CFU stimulus/checker block.
package cfu_tb_pkg;

  // Run-level states of the checker.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  // Fibonacci tap masks: 16-bit uses bits 15,14,12,3; 32-bit uses bits 31,21,1,0.
  localparam logic [31:0] LFSR16_TAPS = 32'h0000_D008;
  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

  // XNOR feedback, so the all-zero state is legal and all-ones is the lock-up state.
  function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
    return ~(^(state & taps));
  endfunction

endpackage

// File: rtl/cfu_tb_fifo.sv
// Outstanding-request FIFO: DEPTH entries, pointer-plus-wrap-bit full/empty.
module cfu_tb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  // DEPTH is a power of two, so masking folds the pointer onto the storage index.
  assign wr_idx = wr_ptr[AW-1:0] & AW'(DEPTH - 1);
  assign rd_idx = rd_ptr[AW-1:0] & AW'(DEPTH - 1);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_idx];

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

  // Pointer update; flush discards everything outstanding.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cfu_stim_checker.sv
// LFSR-driven request generator plus in-order response checker for one CFU.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | issuing requests and checking responses
// ST_DRAIN | all requests issued, waiting for remaining responses
// ST_DONE  | run finished (normally or by timeout), done held high
module cfu_stim_checker
  import cfu_tb_pkg::*;
#(
  parameter int          LFSR_W      = 16,
  parameter int unsigned SEED        = 0,
  parameter int          N_REQS      = 256,
  parameter int          DEPTH       = 4,
  parameter int          FUNC_ID_W   = 1,
  parameter int          REQ_ID_W    = 6,
  parameter int          REQ_INPUTS  = 2,
  parameter int          REQ_DATA_W  = 32,
  parameter int          RESP_DATA_W = 32,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [REQ_ID_W-1:0]              req_id,
  output logic [FUNC_ID_W-1:0]             req_func,
  output logic [REQ_INPUTS*REQ_DATA_W-1:0] req_data,
  input  logic                             resp_valid,
  output logic                             resp_ready,
  input  logic [REQ_ID_W-1:0]              resp_id,
  input  logic [RESP_DATA_W-1:0]           resp_data,
  input  logic                             resp_status,
  output logic [FUNC_ID_W-1:0]             model_func,
  output logic [REQ_INPUTS*REQ_DATA_W-1:0] model_data,
  input  logic [RESP_DATA_W-1:0]           model_exp,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      pass_cnt,
  output logic [15:0]                      fail_cnt,
  output logic                             timeout
);

  localparam int          DATA_W   = REQ_INPUTS * REQ_DATA_W;
  localparam logic [31:0] TAPS     = (LFSR_W == 32) ? LFSR32_TAPS : LFSR16_TAPS;
  localparam int          TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [16:0] N_REQS_V = 17'(N_REQS);

  // Record widths follow this instance's parameters, so the type is declared here.
  typedef struct packed {
    logic [REQ_ID_W-1:0]  id;
    logic [FUNC_ID_W-1:0] func;
    logic [DATA_W-1:0]    data;
  } req_rec_t;

  chk_state_e          state_q;
  chk_state_e          state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_nxt;
  logic [16:0]         issue_cnt_q;
  logic [15:0]         pass_cnt_q;
  logic [15:0]         fail_cnt_q;
  logic                timeout_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [DATA_W-1:0]   op_data;

  req_rec_t            wr_rec;
  req_rec_t            head_rec;
  logic                fifo_full;
  logic                fifo_empty;
  logic                req_fire;
  logic                resp_fire;
  logic                resp_ok;
  logic                stray_resp;
  logic                in_run;
  logic                start_run;
  logic                tmr_expire;

  // Operand k: LFSR rotated left by 7*k, then replicated/truncated to operand width.
  for (genvar k = 0; k < REQ_INPUTS; k++) begin : g_op
    localparam int ROT  = (k * 7) % LFSR_W;
    localparam int REPS = (REQ_DATA_W + LFSR_W - 1) / LFSR_W;
    logic [LFSR_W-1:0]      rot;
    logic [REPS*LFSR_W-1:0] rep;
    assign rot = (lfsr_q << ROT) | (lfsr_q >> ((LFSR_W - ROT) % LFSR_W));
    assign rep = {REPS{rot}};
    assign op_data[k*REQ_DATA_W +: REQ_DATA_W] = rep[REQ_DATA_W-1:0];
  end

  assign lfsr_nxt = {lfsr_q[LFSR_W-2:0], lfsr_fb(32'(lfsr_q), TAPS)};

  assign req_id   = issue_cnt_q[REQ_ID_W-1:0];
  assign req_func = lfsr_q[FUNC_ID_W-1:0];
  assign req_data = op_data;

  assign wr_rec.id   = req_id;
  assign wr_rec.func = req_func;
  assign wr_rec.data = op_data;

  assign model_func = head_rec.func;
  assign model_data = head_rec.data;

  assign resp_ready = !fifo_empty;
  assign req_fire   = req_valid && req_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign resp_ok    = (resp_id == head_rec.id) && !resp_status && (resp_data == model_exp);
  assign in_run     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign stray_resp = resp_valid && fifo_empty && in_run;
  assign start_run  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // The age timer hits terminal count while the head is still waiting.
  assign tmr_expire = in_run && !fifo_empty && !resp_fire && (tmr_q == TMR_W'(1));

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign timeout  = timeout_q;

  cfu_tb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(req_rec_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tmr_expire),
    .push  (req_fire),
    .wdata (wr_rec),
    .pop   (resp_fire),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and run-level outputs.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        req_valid = !fifo_full && (issue_cnt_q < N_REQS_V);
        if (tmr_expire)                   state_d = ST_DONE;
        else if (issue_cnt_q == N_REQS_V) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (tmr_expire || fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stimulus LFSR, issue count, result counters and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_W'(SEED);
      issue_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else if (start_run) begin
      issue_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (req_fire) begin
        lfsr_q      <= lfsr_nxt;
        issue_cnt_q <= issue_cnt_q + 17'd1;
      end
      if (resp_fire) begin
        if (resp_ok) begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        end
      end else if (stray_resp) begin
        if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
      end
      if (tmr_expire) timeout_q <= 1'b1;
    end
  end

  // Head-of-queue age timer: reload on empty or pop, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || resp_fire) tmr_q <= TMR_W'(TIMEOUT);
    else if (tmr_q != '0)               tmr_q <= tmr_q - TMR_W'(1);
  end

endmodule

// File: tb/tb_cfu_stim_checker.sv
// Directed bench for cfu_stim_checker with a behavioural CFU and golden model.
module tb_cfu_stim_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_id;
  logic        req_func;
  logic [63:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_status;
  logic        model_func;
  logic [63:0] model_data;
  logic [31:0] model_exp;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        timeout;

  always #5 clk = ~clk;

  cfu_stim_checker #(
    .LFSR_W(16), .SEED(0), .N_REQS(256), .DEPTH(4), .FUNC_ID_W(1), .REQ_ID_W(6),
    .REQ_INPUTS(2), .REQ_DATA_W(32), .RESP_DATA_W(32), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_func(req_func), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_status(resp_status),
    .model_func(model_func), .model_data(model_data), .model_exp(model_exp),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout(timeout)
  );

  // CFU behaviour knobs
  int lat;
  bit stall;
  bit gfault;
  bit swap;
  bit drop;

  typedef struct {
    logic [5:0]  id;
    logic [31:0] d;
    int          due;
  } ent_t;

  ent_t        cfu_q[$];
  int          ncyc;
  int          resp_n;
  int          issued_n;
  int          max_out;
  bit          saw_full_stall;
  int          rec_n;
  logic [63:0] rec[4];

  // hand-derived first four request payloads for SEED=0 (lfsr 0000,0001,0003,0007)
  logic [63:0] exp4[4] = '{64'h00000000_00000000, 64'h00800080_00010001,
                           64'h01800180_00030003, 64'h03800380_00070007};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural CFU: decisions made on the falling edge, handshakes land on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      cfu_q.delete();
      resp_valid     = 1'b0;
      resp_id        = '0;
      resp_data      = '0;
      req_ready      = 1'b0;
      model_exp      = '0;
      resp_n         = 0;
      issued_n       = 0;
      max_out        = 0;
      saw_full_stall = 1'b0;
      rec_n          = 0;
      ncyc           = 0;
    end else begin
      if (issued_n - resp_n > max_out) max_out = issued_n - resp_n;
      if (busy && !req_valid && issued_n < 256 && (issued_n - resp_n) == 4)
        saw_full_stall = 1'b1;

      model_exp  = model_data[31:0] + ((gfault && resp_n == 10) ? 32'd1 : 32'd0);
      resp_valid = 1'b0;
      if (cfu_q.size() > 0 && cfu_q[0].due <= ncyc && !(drop && resp_n >= 5) &&
          (!stall || $urandom_range(1, 0) == 1)) begin
        resp_valid = 1'b1;
        resp_data  = cfu_q[0].d;
        resp_id    = cfu_q[0].id;
        if (swap && resp_n == 3) resp_id = 6'd4;
        if (swap && resp_n == 4) resp_id = 6'd3;
        if (resp_ready) begin
          void'(cfu_q.pop_front());
          resp_n++;
        end
      end

      req_ready = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (req_valid && req_ready) begin
        cfu_q.push_back('{id: req_id, d: req_data[31:0], due: ncyc + lat});
        if (rec_n < 4) begin
          rec[rec_n] = req_data;
          rec_n++;
        end
        issued_n++;
      end
      ncyc++;
    end
  end

  task automatic reset_dut(input int l, input bit st, input bit gf, input bit sw, input bit dr);
    lat = l; stall = st; gfault = gf; swap = sw; drop = dr;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_req_valid"},  req_valid,  0);
    chk({pfx, "_resp_ready"}, resp_ready, 0);
    chk({pfx, "_busy"},       busy,       0);
    chk({pfx, "_done"},       done,       0);
    chk({pfx, "_timeout"},    timeout,    0);
    chk({pfx, "_pass"},       pass_cnt,   0);
    chk({pfx, "_fail"},       fail_cnt,   0);
  endtask

  task automatic do_run(input string tag, input bit poke, input int budget, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < budget) begin
      start = (poke && cycles == 5);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_first4(input string tag);
    chk({tag, "_rec_n"}, (rec_n >= 4), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_req_data%0d", tag, i), rec[i], exp4[i]);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; resp_status = 1'b0;
    lat = 1; stall = 0; gfault = 0; swap = 0; drop = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // echo CFU, no stalls, with an ignored start mid-run
    reset_dut(1, 0, 0, 0, 0);
    do_run("echo", 1'b1, 2000, cyc);
    chk("echo_pass", pass_cnt, 256);
    chk("echo_fail", fail_cnt, 0);
    chk("echo_timeout", timeout, 0);
    chk("echo_cycles_le_270", (cyc <= 270), 1);
    check_first4("echo");
    repeat (3) @(posedge clk);
    #1;
    chk("echo_done_held", done, 1);
    chk("echo_busy_low", busy, 0);

    // random stalls on both handshakes
    reset_dut(1, 1, 0, 0, 0);
    do_run("stall", 1'b0, 5000, cyc);
    chk("stall_pass", pass_cnt, 256);
    chk("stall_fail", fail_cnt, 0);
    check_first4("stall");

    // six-cycle latency fills the outstanding window
    reset_dut(6, 0, 0, 0, 0);
    do_run("lat6", 1'b0, 5000, cyc);
    chk("lat6_pass", pass_cnt, 256);
    chk("lat6_max_out", max_out, 4);
    chk("lat6_full_stall", saw_full_stall, 1);

    // golden model wrong for request 10 only
    reset_dut(1, 0, 1, 0, 0);
    do_run("golden", 1'b0, 2000, cyc);
    chk("golden_pass", pass_cnt, 255);
    chk("golden_fail", fail_cnt, 1);

    // responses 3 and 4 carry swapped ids
    reset_dut(1, 0, 0, 1, 0);
    do_run("swap", 1'b0, 2000, cyc);
    chk("swap_pass", pass_cnt, 254);
    chk("swap_fail", fail_cnt, 2);

    // CFU goes silent from response 5 on
    reset_dut(1, 0, 0, 0, 1);
    do_run("drop", 1'b0, 2000, cyc);
    chk("drop_timeout", timeout, 1);
    chk("drop_pass", pass_cnt, 5);
    chk("drop_busy", busy, 0);
    chk("drop_resp_ready", resp_ready, 0);

    // reset in the middle of a run, then a clean rerun
    reset_dut(1, 0, 0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrst");
    @(posedge clk); #1;
    do_run("rerun", 1'b0, 2000, cyc);
    chk("rerun_pass", pass_cnt, 256);
    chk("rerun_fail", fail_cnt, 0);
    check_first4("rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
